imem_arbiter: RTL
=================

# imem_arbiter

Arbitrates the single port of the byte-addressed instruction memory between two requesters: the fetch unit (word reads) and the program loader (word writes during boot or reprogramming). It sits directly in front of the instruction memory, drives its address/read_write/data_in pins, and registers read data back to fetch. Loader has priority, bounded by a starvation limit, and may lock the port for a burst.

## Interface
- ADDRWIDTH, 32, address width
- DATAWIDTH, 32, data width
- MEM_BYTES, 32, instruction memory size in bytes (multiple of 4)
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- f_req  in  1  fetch read request; held with f_addr stable until f_gnt
- f_addr  in  ADDRWIDTH  fetch byte address
- f_gnt  out  1  fetch access performed this cycle (combinational)
- f_rvalid  out  1  f_rdata valid (registered, 1 cycle after f_gnt)
- f_rdata  out  DATAWIDTH  read word
- f_err  out  1  qualifies f_rvalid: access rejected
- l_req  in  1  loader write request; held with l_addr/l_wdata stable until l_gnt
- l_lock  in  1  loader keeps exclusive ownership while high
- l_addr  in  ADDRWIDTH  loader byte address
- l_wdata  in  DATAWIDTH  write word
- l_gnt  out  1  write performed this cycle (combinational)
- l_done  out  1  pulse, 1 cycle after l_gnt
- l_err  out  1  qualifies l_done: write suppressed
- mem_address  out  ADDRWIDTH  to memory address
- mem_read_write  out  1  to memory, 1 = write
- mem_data_in  out  DATAWIDTH  to memory write data
- mem_data_out  in  DATAWIDTH  from memory, combinational read
- busy  out  1  state != IDLE

## Operation
- One memory access per cycle. States: IDLE, OWN_F, OWN_L, LOCKED; state = owner of previous cycle's access.
- Winner selection (per cycle): LOCKED -> loader only, fetch never granted; else if both request -> loader, unless starve_cnt == STARVE_LIMIT, then fetch; else the sole requester.
- Transitions: winner fetch -> OWN_F; winner loader with l_lock=1 -> LOCKED; winner loader otherwise -> OWN_L; no request -> IDLE. LOCKED exits only when l_lock=0 (to IDLE, or OWN_F/OWN_L per winner that cycle).
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle f_req=1 and f_gnt=0 outside LOCKED; clears on f_gnt; held in LOCKED.
- Fetch grant: mem_address=f_addr, mem_read_write=0; f_rdata <= mem_data_out, f_rvalid <= 1 at next edge.
- Loader grant: mem_address=l_addr, mem_read_write=1, mem_data_in=l_wdata; memory commits at the same edge; l_done <= 1.
- No grant: mem_address=0, mem_read_write=0, mem_data_in=0.
- f_gnt and l_gnt never both high.

## Timing
- Grant latency 0 cycles when uncontended; read data latency 1 cycle after f_gnt; l_done 1 cycle after l_gnt.
- Back-to-back grants to the same requester allowed every cycle.
- Read of address written in cycle N, issued in cycle N+1, returns new data.
- Reset (rst_n=0 at an edge): state IDLE, starve_cnt 0, f_rvalid/f_rdata/f_err/l_done/l_err 0; combinational grants forced 0 and memory pins at idle values while rst_n=0; in-flight rvalid/done dropped.
- Dropping a request before its grant is illegal; behaviour unspecified.

## Configuration
- IMEM_ARB_BOUNDS_CHECK_EN defined: access with addr[1:0]!=0 or addr > MEM_BYTES-4 is still granted but not issued to memory (memory pins idle); fetch returns f_rvalid=1, f_err=1, f_rdata=0; loader returns l_done=1, l_err=1, no write.
- Undefined: addresses pass through unchecked; f_err and l_err tied 0.

## Test plan
- f_req alone, f_addr=0x4 after preloading 0x413903b3 -> f_gnt same cycle, next cycle f_rvalid=1, f_rdata=0x413903b3, f_err=0.
- l_req, l_addr=0x8, l_wdata=0xDEADBEEF, then f_req addr 0x8 -> l_done next cycle, fetch returns 0xDEADBEEF.
- f_req and l_req both held high continuously, STARVE_LIMIT=4 -> 4 loader grants, 1 fetch grant, repeating; never both grants.
- l_lock=1 with f_req high for 10 cycles -> zero fetch grants, starve_cnt frozen; lock drop -> state exits LOCKED, fetch granted within STARVE_LIMIT+1 cycles.
- With IMEM_ARB_BOUNDS_CHECK_EN: f_addr=0x2 -> f_err=1, f_rdata=0; l_addr=0x20 -> l_err=1, memory contents unchanged.
- rst_n=0 asserted one cycle after f_gnt -> f_rvalid stays 0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction memory arbiter between the fetch unit
// (word reads) and the program loader (word writes). The loader has priority,
// but fetch is forced through after STARVE_LIMIT consecutive denials. The
// loader can hold the port exclusively with l_lock.
// Optional build macro: IMEM_ARB_BOUNDS_CHECK_EN enables address checking.
// A misaligned or out-of-range access is still granted, but it is not issued
// to memory and is answered with an error.
module imem_arbiter #(
  parameter int ADDRWIDTH    = 32,
  parameter int DATAWIDTH    = 32,
  parameter int MEM_BYTES    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req,
  input  logic [ADDRWIDTH-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [DATAWIDTH-1:0] f_rdata,
  output logic                 f_err,
  input  logic                 l_req,
  input  logic                 l_lock,
  input  logic [ADDRWIDTH-1:0] l_addr,
  input  logic [DATAWIDTH-1:0] l_wdata,
  output logic                 l_gnt,
  output logic                 l_done,
  output logic                 l_err,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic                 mem_read_write,
  output logic [DATAWIDTH-1:0] mem_data_in,
  input  logic [DATAWIDTH-1:0] mem_data_out,
  output logic                 busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, OWN_F, OWN_L, LOCKED} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic            lock_hold;
  logic            starved;
  logic            f_bad;
  logic            l_bad;

`ifdef IMEM_ARB_BOUNDS_CHECK_EN
  localparam logic [ADDRWIDTH-1:0] LAST_WORD = ADDRWIDTH'(MEM_BYTES - 4);
  assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr > LAST_WORD);
  assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr > LAST_WORD);
`else
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif

  // The loader keeps the port only while it was the locked owner and still holds l_lock.
  assign lock_hold = (state == LOCKED) && l_lock;
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
  assign busy      = (state != IDLE);

  // Winner selection: fetch wins only when it is alone or starved; otherwise the loader wins.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      f_gnt = !lock_hold && f_req && (!l_req || starved);
      l_gnt = l_req && !f_gnt;
    end
  end

  // Memory pins follow the winner. Rejected and idle cycles leave the pins at zero.
  always_comb begin
    mem_address    = '0;
    mem_read_write = 1'b0;
    mem_data_in    = '0;
    if (f_gnt && !f_bad) begin
      mem_address = f_addr;
    end else if (l_gnt && !l_bad) begin
      mem_address    = l_addr;
      mem_read_write = 1'b1;
      mem_data_in    = l_wdata;
    end
  end

  // Ownership state, starvation counter and registered responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      f_rvalid   <= 1'b0;
      f_rdata    <= '0;
      f_err      <= 1'b0;
      l_done     <= 1'b0;
      l_err      <= 1'b0;
    end else begin
      if (lock_hold)  state <= LOCKED;
      else if (f_gnt) state <= OWN_F;
      else if (l_gnt) state <= l_lock ? LOCKED : OWN_L;
      else            state <= IDLE;

      if (f_gnt)
        starve_cnt <= '0;
      else if ((state != LOCKED) && f_req && !starved)
        starve_cnt <= starve_cnt + SW'(1);

      f_rvalid <= f_gnt;
      f_err    <= f_gnt && f_bad;
      if (f_gnt)
        f_rdata <= f_bad ? '0 : mem_data_out;
      l_done   <= l_gnt;
      l_err    <= l_gnt && l_bad;
    end
  end

endmodule
